// File: rtl/serie_paralelo_rx.sv
// ============================================================================
// Module      : serie_paralelo_rx
// Description : Serial-to-parallel receiver that hunts for comma alignment
//               and recovers MSB-first bytes. The optional delivered-byte
//               counter is enabled by defining RX_BYTE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serie_paralelo_rx #(
    parameter logic [7:0]  COMMA   = 8'hBC,
    parameter int unsigned N_COMMA = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_inS,
    output logic [7:0]       data_outP,
    output logic             valid_out,
    output logic             active
`ifdef RX_BYTE_CNT_EN
    ,
    output logic [CNT_W-1:0] byte_count
`endif
);

    localparam logic [1:0] c_st_hunt   = 2'd0;
    localparam logic [1:0] c_st_align  = 2'd1;
    localparam logic [1:0] c_st_active = 2'd2;
    localparam logic [3:0] c_n_comma   = 4'(N_COMMA);

    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_comma_cnt;
    logic [1:0] r_state;

    logic [7:0] w_sr_n;
    logic       w_comma;
    logic       w_boundary;

    // Comparisons use the window including the bit sampled on this edge.
    assign w_sr_n     = {r_sr[6:0], data_inS};
    assign w_comma    = (w_sr_n == COMMA);
    assign w_boundary = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_sr        <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_comma_cnt <= 4'd0;
            r_state     <= c_st_hunt;
            data_outP   <= 8'h00;
            valid_out   <= 1'b0;
            active      <= 1'b0;
`ifdef RX_BYTE_CNT_EN
            byte_count  <= '0;
`endif
        end else begin
            r_sr      <= w_sr_n;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            case (r_state)
                c_st_hunt: begin
                    // A match fixes the byte phase: next boundary is 8 edges on.
                    if (w_comma) begin
                        r_bit_cnt   <= 3'd0;
                        r_comma_cnt <= 4'd1;
                        if (N_COMMA == 1) begin
                            r_state <= c_st_active;
                            active  <= 1'b1;
                        end else begin
                            r_state <= c_st_align;
                        end
                    end
                end
                c_st_align: begin
                    if (w_boundary) begin
                        if (w_comma) begin
                            r_comma_cnt <= r_comma_cnt + 4'd1;
                            if (r_comma_cnt + 4'd1 == c_n_comma) begin
                                r_state <= c_st_active;
                                active  <= 1'b1;
                            end
                        end else begin
                            r_state     <= c_st_hunt;
                            r_comma_cnt <= 4'd0;
                        end
                    end
                end
                c_st_active: begin
                    // Commas clear valid but leave the last data byte visible.
                    if (w_boundary) begin
                        if (w_comma) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_outP <= w_sr_n;
                            valid_out <= 1'b1;
`ifdef RX_BYTE_CNT_EN
                            byte_count <= byte_count + 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= c_st_hunt;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serie_paralelo_rx.sv
// ============================================================================
// Module      : tb_serie_paralelo_rx
// Description : Scoreboard bench for serie_paralelo_rx (byte-level expectations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serie_paralelo_rx;

`ifdef RX_BYTE_CNT_EN
    localparam int unsigned c_cnt_w = 4;
`else
    localparam int unsigned c_cnt_w = 16;
`endif
    localparam logic [7:0] c_comma = 8'hBC;

    logic               clk_8f   = 1'b0;
    logic               reset    = 1'b1;
    logic               data_inS = 1'b0;
    logic [7:0]         data_outP;
    logic               valid_out;
    logic               active;
`ifdef RX_BYTE_CNT_EN
    logic [c_cnt_w-1:0] byte_count;
`endif

    serie_paralelo_rx #(
        .COMMA   (c_comma),
        .N_COMMA (4),
        .CNT_W   (c_cnt_w)
    ) dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_inS  (data_inS),
        .data_outP (data_outP),
        .valid_out (valid_out),
        .active    (active)
`ifdef RX_BYTE_CNT_EN
        ,
        .byte_count(byte_count)
`endif
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       act;
    } exp_t;

    localparam exp_t c_zero = '{data: 8'h00, valid: 1'b0, act: 1'b0};

    exp_t sb[$];
    exp_t r_cur;       // outputs expected since the last byte boundary
    exp_t r_last;      // most recently pushed expectation
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, "_data"},   32'(data_outP), 32'(e.data));
        check({tag, "_valid"},  32'(valid_out), 32'(e.valid));
        check({tag, "_active"}, 32'(active),    32'(e.act));
    endtask

    // Drive one bit; return #1 after the edge that sampled it.
    task automatic send_bit(input logic b);
        data_inS = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input exp_t e);
        sb.push_back(e);
        r_last = e;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i != 0) check_outs({tag, "_hold"}, r_cur);
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            r_cur = sb.pop_front();
            check_outs(tag, r_cur);
        end
    endtask

    // Expected outputs for a byte received while aligned.
    function automatic exp_t model_active(input logic [7:0] b);
        exp_t e;
        if (b == c_comma) begin
            e = '{data: r_last.data, valid: 1'b0, act: 1'b1};
        end else begin
            e = '{data: b, valid: 1'b1, act: 1'b1};
        end
        return e;
    endfunction

    task automatic send_data(input string tag, input logic [7:0] b);
        exp_t e;
        e = model_active(b);
        if (e.valid) exp_cnt++;
        send_byte(tag, b, e);
    endtask

    task automatic align4(input string tag);
        for (int k = 0; k < 3; k++) send_byte({tag, "_bc"}, c_comma, c_zero);
        send_byte({tag, "_bc4"}, c_comma, '{data: 8'h00, valid: 1'b0, act: 1'b1});
    endtask

    task automatic do_reset(input string tag, input int cycles);
        reset = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            send_bit(1'($urandom_range(0, 1)));
            check_outs({tag, "_in_rst"}, c_zero);
        end
        reset = 1'b0;
        sb.delete();
        r_cur   = c_zero;
        r_last  = c_zero;
        exp_cnt = 0;
        send_bit(1'b0);
        check_outs({tag, "_post_rst"}, c_zero);
    endtask

    initial begin
        r_cur  = c_zero;
        r_last = c_zero;

        // Reset behaviour with random serial input.
        do_reset("rst", 3);

        // Basic alignment and one data byte, held across the next byte.
        align4("t2");
        send_data("t2_55", 8'h55);
        send_data("t2_bc", c_comma);

        // Alignment at a non-zero bit offset.
        do_reset("rst3", 1);
        for (int k = 0; k < 3; k++) begin
            send_bit(1'b0);
            check_outs("t3_pad", c_zero);
        end
        align4("t3");
        send_data("t3_a3", 8'hA3);
        send_data("t3_bc", c_comma);
        send_data("t3_0f", 8'h0F);

        // Alignment aborted by a data byte, then re-hunt.
        do_reset("rst4", 1);
        for (int k = 0; k < 3; k++) send_byte("t4_bc", c_comma, c_zero);
        send_byte("t4_12", 8'h12, c_zero);
        align4("t4");
        send_data("t4_7e", 8'h7E);

        // Reset in the middle of a byte while active.
        do_reset("rst5", 1);
        align4("t5");
        send_data("t5_c3", 8'hC3);
        send_bit(1'b0);
        check_outs("t5_part", r_cur);
        send_bit(1'b1);
        check_outs("t5_part", r_cur);
        send_bit(1'b0);
        check_outs("t5_part", r_cur);
        reset = 1'b1;
        send_bit(1'b1);
        check_outs("t5_midrst", c_zero);
        do_reset("rst5b", 1);
        align4("t5r");
        send_data("t5_99", 8'h99);

        // Long data run with an interleaved comma; counter wraps when narrow.
        do_reset("rst6", 1);
        align4("t6");
        for (int k = 0; k < 17; k++) begin
            send_data("t6_data", 8'(k * 13 + 1));
            if (k == 8) send_data("t6_bc", c_comma);
        end
`ifdef RX_BYTE_CNT_EN
        check("t6_byte_count", 32'(byte_count), 32'(exp_cnt % (1 << c_cnt_w)));
`endif
        check("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
